// File: rtl/load_store_unit.sv
// load_store_unit: turns one byte/half/word load or store into a word-wide
// data-memory transaction. It drives byte enables and lane-replicated store
// data, then aligns and sign/zero-extends the load data for writeback.
//
// Ports:
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   req_valid_i / req_ready_o     request handshake from execute
//   req_wen_i                     1 store, 0 load
//   req_size_i                    00 byte, 01 half, 10 word, 11 illegal
//   req_sign_i                    1 sign-extend load, 0 zero-extend
//   req_addr_i, req_wdata_i       byte address, store data
//   req_rd_i                      destination register, echoed on rsp_rd_o
//   mem_req_o / mem_gnt_i         memory request, held until granted
//   mem_we_o, mem_addr_o          write flag, word address
//   mem_be_o, mem_wdata_o         byte enables, lane-positioned write data
//   mem_rvalid_i, mem_rdata_i     read data return
//   rsp_valid_o / rsp_ready_i     response handshake to writeback
//   rsp_data_o, rsp_rd_o          extended load data (0 for stores/errors), rd
//   rsp_err_o                     misaligned or illegal size, no memory access
//
// Optional feature: define LSU_MISALIGNED_SPLIT_EN to turn misaligned half/word
// accesses into two word accesses instead of reporting an error.
module load_store_unit #(
  parameter int unsigned ADDRESS_BITS = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_wen_i,
  input  logic [1:0]              req_size_i,
  input  logic                    req_sign_i,
  input  logic [ADDRESS_BITS-1:0] req_addr_i,
  input  logic [31:0]             req_wdata_i,
  input  logic [4:0]              req_rd_i,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDRESS_BITS-3:0] mem_addr_o,
  output logic [3:0]              mem_be_o,
  output logic [31:0]             mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [31:0]             mem_rdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [31:0]             rsp_data_o,
  output logic [4:0]              rsp_rd_o,
  output logic                    rsp_err_o
);

  localparam int unsigned MEM_AW = ADDRESS_BITS - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
`ifdef LSU_MISALIGNED_SPLIT_EN
    S_REQ2,
    S_WAIT2,
`endif
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [4:0]        rsp_rd_q, rsp_rd_d;
  logic              rsp_err_q, rsp_err_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [1:0]        off_q, off_d;

  logic [1:0]        off_c;
  logic              misaligned_c;
  logic              illegal_c;
  logic [3:0]        be_lo_c;
  logic [31:0]       wd_lo_c;

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic              split_q, split_d;
  logic [3:0]        be_hi_q, be_hi_d;
  logic [31:0]       wd_hi_q, wd_hi_d;
  logic [31:0]       rdata1_q, rdata1_d;
  logic [3:0]        mask_c;
  logic [7:0]        be64_c;
  logic [63:0]       wd64_c;
  logic [31:0]       merged_c;
`endif

  // Pick the addressed byte/half out of a read word and extend it to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] size, input logic sign);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   extract = sign ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   extract = sign ? {{16{h[15]}}, h} : {16'h0, h};
      default: extract = w;
    endcase
  endfunction

  // Request decode: lane enables, store data placement, error classification.
  always_comb begin
    off_c        = req_addr_i[1:0];
    misaligned_c = ((req_size_i == 2'b01) && off_c[0]) ||
                   ((req_size_i == 2'b10) && (off_c != 2'b00));
    be_lo_c      = 4'b1111;
    wd_lo_c      = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        be_lo_c = 4'b0001 << off_c;
        wd_lo_c = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        be_lo_c = 4'b0011 << off_c;
        wd_lo_c = {2{req_wdata_i[15:0]}};
      end
      default: ;
    endcase
`ifdef LSU_MISALIGNED_SPLIT_EN
    illegal_c = (req_size_i == 2'b11);
    mask_c    = (req_size_i == 2'b01) ? 4'b0011 : 4'b1111;
    be64_c    = {4'b0000, mask_c} << off_c;
    wd64_c    = {32'h0, req_wdata_i} << {off_c, 3'b000};
    // Two-word read window shifted down so the access starts at lane 0.
    merged_c  = 32'({mem_rdata_i, rdata1_q} >> {off_q, 3'b000});
`else
    illegal_c = (req_size_i == 2'b11) || misaligned_c;
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_err_d   = rsp_err_q;
    size_d      = size_q;
    sign_d      = sign_q;
    off_d       = off_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
    split_d     = split_q;
    be_hi_d     = be_hi_q;
    wd_hi_d     = wd_hi_q;
    rdata1_d    = rdata1_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          req_ready_d = 1'b0;
          size_d      = req_size_i;
          sign_d      = req_sign_i;
          off_d       = off_c;
          rsp_rd_d    = req_rd_i;
          mem_we_d    = req_wen_i;
          if (illegal_c) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_addr_d  = req_addr_i[ADDRESS_BITS-1:2];
            mem_be_d    = be_lo_c;
            mem_wdata_d = wd_lo_c;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_d     = misaligned_c;
            if (misaligned_c) begin
              mem_be_d    = be64_c[3:0];
              mem_wdata_d = wd64_c[31:0];
              be_hi_d     = be64_c[7:4];
              wd_hi_d     = wd64_c[63:32];
            end
`endif
          end
        end
      end
      S_REQ: begin
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            state_d = S_WAIT;
`ifdef LSU_MISALIGNED_SPLIT_EN
          end else if (split_q) begin
            state_d     = S_REQ2;
            mem_req_d   = 1'b1;
            mem_addr_d  = mem_addr_q + MEM_AW'(1);
            mem_be_d    = be_hi_q;
            mem_wdata_d = wd_hi_q;
`endif
          end else begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = '0;
          end
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
          if (split_q) begin
            rdata1_d    = mem_rdata_i;
            state_d     = S_REQ2;
            mem_req_d   = 1'b1;
            mem_addr_d  = mem_addr_q + MEM_AW'(1);
            mem_be_d    = be_hi_q;
            mem_wdata_d = wd_hi_q;
          end else
`endif
          begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = extract(mem_rdata_i, off_q, size_q, sign_q);
          end
        end
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      S_REQ2: begin
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = '0;
          end else begin
            state_d = S_WAIT2;
          end
        end
      end
      S_WAIT2: begin
        if (mem_rvalid_i) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = extract(merged_c, 2'b00, size_q, sign_q);
        end
      end
`endif
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        mem_req_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      rsp_err_q   <= 1'b0;
      size_q      <= '0;
      sign_q      <= 1'b0;
      off_q       <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q     <= 1'b0;
      be_hi_q     <= '0;
      wd_hi_q     <= '0;
      rdata1_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_err_q   <= rsp_err_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      off_q       <= off_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q     <= split_d;
      be_hi_q     <= be_hi_d;
      wd_hi_q     <= wd_hi_d;
      rdata1_q    <= rdata1_d;
`endif
    end
  end

  assign req_ready_o = req_ready_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_rd_o    = rsp_rd_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
